// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator control slice:
// error bit positions, minimum legal rate and the comb tag bundle.
package cic_pkg;

   localparam int ERR_OVERRUN = 0;
   localparam int ERR_BADRATE = 1;
   localparam int MIN_RATE    = 2;

   // One entry of the comb-latency tag pipeline
   typedef struct packed {
      logic vld;
      logic keep;
   } tag_t;

endpackage

// File: rtl/cic_rate_counter.sv
// Input sample counter, rate register and pending rate change.
// Ports: clk, reset_n, in_valid, cfg_rate/cfg_valid/cfg_ready,
// dec_strobe, rate_apply (change taking effect), bad_rate, cur_rate.
module cic_rate_counter
   import cic_pkg::*;
#(
   parameter int RATE_WIDTH   = 5,
   parameter int DEFAULT_RATE = 24
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [RATE_WIDTH-1:0] cfg_rate,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic                  dec_strobe,
   output logic                  rate_apply,
   output logic                  bad_rate,
   output logic [RATE_WIDTH-1:0] cur_rate
);

   logic [RATE_WIDTH-1:0] count;
   logic [RATE_WIDTH-1:0] rate_q;
   logic [RATE_WIDTH-1:0] pend_rate;
   logic                  pend;
   logic                  at_wrap;
   logic                  cfg_fire;
   logic                  cfg_bad;

   assign at_wrap    = (count == rate_q - RATE_WIDTH'(1));
   assign dec_strobe = reset_n && in_valid && at_wrap;
   assign cfg_ready  = !pend;
   assign cfg_fire   = reset_n && cfg_valid && !pend;
   assign cfg_bad    = (cfg_rate < RATE_WIDTH'(MIN_RATE));
   assign bad_rate   = cfg_fire && cfg_bad;
   // A pending rate only lands on a decimation boundary
   assign rate_apply = dec_strobe && pend;
   assign cur_rate   = rate_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count     <= '0;
         rate_q    <= RATE_WIDTH'(DEFAULT_RATE);
         pend_rate <= RATE_WIDTH'(DEFAULT_RATE);
         pend      <= 1'b0;
      end else begin
         if (in_valid) begin
            count <= at_wrap ? '0 : count + RATE_WIDTH'(1);
         end
         if (rate_apply) begin
            rate_q <= pend_rate;
            pend   <= 1'b0;
         end else if (cfg_fire && !cfg_bad) begin
            pend_rate <= cfg_rate;
            pend      <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC comb-section sequencer: strobes the combs, blanks warm-up outputs,
// buffers comb output in a valid/ready register and flags errors.
// Ports: clk, reset_n, in_valid, cfg_*, dec_strobe, comb_clear, cic_data,
// out_data/out_valid/out_ready, out_error[1:0], cur_rate.
module cic_decim_ctrl
   import cic_pkg::*;
#(
   parameter int NUM_STAGES   = 4,
   parameter int DATA_WIDTH   = 19,
   parameter int RATE_WIDTH   = 5,
   parameter int DEFAULT_RATE = 24,
   parameter int COMB_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [RATE_WIDTH-1:0] cfg_rate,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic                  dec_strobe,
   output logic                  comb_clear,
   input  logic [DATA_WIDTH-1:0] cic_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            out_error,
   output logic [RATE_WIDTH-1:0] cur_rate
);

   localparam int WW = $clog2(NUM_STAGES + 1);

   logic          rate_apply;
   logic          bad_rate;
   logic [WW-1:0] warm;
   logic          keep_now;
   logic          arrive;
   logic          clear_q;
   logic [1:0]    err_q;
   tag_t          tags [COMB_LAT];

   cic_rate_counter #(
      .RATE_WIDTH   (RATE_WIDTH),
      .DEFAULT_RATE (DEFAULT_RATE)
   ) u_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .cfg_rate   (cfg_rate),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .dec_strobe (dec_strobe),
      .rate_apply (rate_apply),
      .bad_rate   (bad_rate),
      .cur_rate   (cur_rate)
   );

   // The boundary strobe of a rate change still sees stale comb delays
   assign keep_now   = !rate_apply && (warm == '0);
   assign arrive     = tags[COMB_LAT-1].vld && tags[COMB_LAT-1].keep;
   assign comb_clear = clear_q;
   assign out_error  = err_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         warm    <= WW'(NUM_STAGES);
         clear_q <= 1'b0;
      end else begin
         clear_q <= rate_apply;
         if (rate_apply) begin
            warm <= WW'(NUM_STAGES);
         end else if (dec_strobe && warm != '0) begin
            warm <= warm - WW'(1);
         end
      end
   end

   // Tag shift register matches the comb pipeline latency
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < COMB_LAT; i++) begin
            tags[i] <= '0;
         end
      end else begin
         tags[0] <= '{vld: dec_strobe, keep: keep_now};
         for (int i = 1; i < COMB_LAT; i++) begin
            tags[i] <= tags[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         err_q     <= '0;
      end else begin
         if (bad_rate) begin
            err_q[ERR_BADRATE] <= 1'b1;
         end
         if (arrive) begin
            if (!out_valid || out_ready) begin
               out_data  <= cic_data;
               out_valid <= 1'b1;
            end else begin
               err_q[ERR_OVERRUN] <= 1'b1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl: warm-up, rate change, gapped input,
// overrun, illegal rate and reset abort.
module tb_cic_decim_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [4:0]  cfg_rate;
   logic        cfg_valid;
   logic        cfg_ready;
   logic        dec_strobe;
   logic        comb_clear;
   logic [18:0] cic_data;
   logic [18:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_error;
   logic [4:0]  cur_rate;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [18:0] first_q;

   always #5 clk = ~clk;

   cic_decim_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .cfg_rate   (cfg_rate),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .dec_strobe (dec_strobe),
      .comb_clear (comb_clear),
      .cic_data   (cic_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_error  (out_error),
      .cur_rate   (cur_rate)
   );

   // Start of a cycle; cic_data carries a cycle-stamped value
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      cic_data = 19'(32'h1000 + cyc);
   endtask

   function automatic logic [18:0] prev_data();
      return 19'(32'h1000 + cyc - 1);
   endfunction

   task automatic do_reset();
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      cfg_valid = 1'b0;
      cfg_rate  = 5'd0;
      out_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (cur_rate !== 5'd24) begin
         errors++;
         $display("FAIL rst_rate got %0d exp 24", cur_rate);
      end
      checks++;
      if (cfg_ready !== 1'b1 || dec_strobe !== 1'b0 || comb_clear !== 1'b0) begin
         errors++;
         $display("FAIL rst_ctl got rdy=%b str=%b clr=%b exp 1 0 0",
                  cfg_ready, dec_strobe, comb_clear);
      end
      checks++;
      if (out_valid !== 1'b0 || out_data !== 19'd0 || out_error !== 2'b00) begin
         errors++;
         $display("FAIL rst_out got v=%b d=%h e=%b exp 0 0 00",
                  out_valid, out_data, out_error);
      end
   endtask

   task automatic test_warmup();
      do_reset();
      for (int k = 0; k < 124; k++) begin
         tick();
         reset_n  = 1'b1;
         in_valid = 1'b1;
         @(negedge clk);
         checks++;
         if (dec_strobe !== ((k % 24) == 23)) begin
            errors++;
            $display("FAIL warm_strobe k=%0d got %b", k, dec_strobe);
         end
         checks++;
         if (out_valid !== (k == 121)) begin
            errors++;
            $display("FAIL warm_valid k=%0d got %b", k, out_valid);
         end
         if (k == 121) begin
            checks++;
            if (out_data !== prev_data()) begin
               errors++;
               $display("FAIL warm_data got %h exp %h", out_data, prev_data());
            end
         end
      end
   endtask

   task automatic test_rate_change();
      do_reset();
      for (int k = 0; k < 68; k++) begin
         tick();
         reset_n   = 1'b1;
         in_valid  = 1'b1;
         cfg_valid = (k == 10);
         cfg_rate  = 5'd8;
         @(negedge clk);
         checks++;
         if (dec_strobe !== (k == 23 || (k >= 24 && (k - 24) % 8 == 7))) begin
            errors++;
            $display("FAIL rc_strobe k=%0d got %b", k, dec_strobe);
         end
         checks++;
         if (cfg_ready !== !(k >= 11 && k <= 23)) begin
            errors++;
            $display("FAIL rc_ready k=%0d got %b", k, cfg_ready);
         end
         checks++;
         if (cur_rate !== ((k >= 24) ? 5'd8 : 5'd24)) begin
            errors++;
            $display("FAIL rc_rate k=%0d got %0d", k, cur_rate);
         end
         checks++;
         if (comb_clear !== (k == 24)) begin
            errors++;
            $display("FAIL rc_clear k=%0d got %b", k, comb_clear);
         end
         checks++;
         if (out_valid !== (k == 65)) begin
            errors++;
            $display("FAIL rc_valid k=%0d got %b", k, out_valid);
         end
      end
   endtask

   task automatic test_gapped_input();
      do_reset();
      for (int k = 0; k < 100; k++) begin
         tick();
         reset_n  = 1'b1;
         in_valid = ((k % 2) == 0);
         @(negedge clk);
         checks++;
         if (dec_strobe !== ((k % 48) == 46)) begin
            errors++;
            $display("FAIL gap_strobe k=%0d got %b", k, dec_strobe);
         end
      end
   endtask

   task automatic test_overrun();
      do_reset();
      for (int k = 0; k < 148; k++) begin
         tick();
         reset_n   = 1'b1;
         in_valid  = 1'b1;
         out_ready = (k == 146);
         @(negedge clk);
         if (k == 121) begin
            first_q = prev_data();
            checks++;
            if (out_valid !== 1'b1 || out_data !== first_q) begin
               errors++;
               $display("FAIL ovr_first got v=%b d=%h exp 1 %h",
                        out_valid, out_data, first_q);
            end
         end
         if (k == 144) begin
            checks++;
            if (out_error !== 2'b00) begin
               errors++;
               $display("FAIL ovr_early got %b exp 00", out_error);
            end
         end
         if (k == 145) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== first_q || out_error !== 2'b01) begin
               errors++;
               $display("FAIL ovr_hold got v=%b d=%h e=%b exp 1 %h 01",
                        out_valid, out_data, out_error, first_q);
            end
         end
         if (k == 147) begin
            checks++;
            if (out_valid !== 1'b0 || out_data !== first_q) begin
               errors++;
               $display("FAIL ovr_drain got v=%b d=%h exp 0 %h",
                        out_valid, out_data, first_q);
            end
         end
      end
   endtask

   task automatic test_bad_rate();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         tick();
         reset_n   = 1'b1;
         cfg_valid = (k == 2);
         cfg_rate  = 5'd1;
         @(negedge clk);
         checks++;
         if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_ready k=%0d got %b exp 1", k, cfg_ready);
         end
      end
      checks++;
      if (out_error !== 2'b10 || cur_rate !== 5'd24) begin
         errors++;
         $display("FAIL bad_flag got e=%b r=%0d exp 10 24", out_error, cur_rate);
      end
   endtask

   task automatic test_reset_abort();
      do_reset();
      for (int k = 0; k < 122; k++) begin
         tick();
         reset_n   = !(k >= 120);
         in_valid  = 1'b1;
         cfg_valid = (k == 119);
         cfg_rate  = 5'd5;
         @(negedge clk);
         if (k == 120) begin
            checks++;
            if (cfg_ready !== 1'b0) begin
               errors++;
               $display("FAIL ab_pend got %b exp 0", cfg_ready);
            end
         end
         if (k == 121) begin
            checks++;
            if (cfg_ready !== 1'b1 || out_valid !== 1'b0 || cur_rate !== 5'd24) begin
               errors++;
               $display("FAIL ab_clear got rdy=%b v=%b r=%0d exp 1 0 24",
                        cfg_ready, out_valid, cur_rate);
            end
         end
      end
      cfg_valid = 1'b0;
      for (int k = 0; k < 122; k++) begin
         tick();
         reset_n  = 1'b1;
         in_valid = 1'b1;
         @(negedge clk);
         checks++;
         if (out_valid !== (k == 121) || dec_strobe !== ((k % 24) == 23)) begin
            errors++;
            $display("FAIL ab_warm k=%0d got v=%b s=%b", k, out_valid, dec_strobe);
         end
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      cfg_valid = 1'b0;
      cfg_rate  = 5'd0;
      out_ready = 1'b1;
      cic_data  = 19'd0;
      test_reset();
      test_warmup();
      test_rate_change();
      test_gapped_input();
      test_overrun();
      test_bad_rate();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
